// File: rtl/reg_alu_array.sv
`default_nettype none
// ============================================================================
//  Module      : reg_alu_array
//  Description : NREGS x WIDTH register-file ALU with load/add/sub/logic ops
//                and a multi-cycle shift-add multiplier behind START/BUSY/DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_alu_array #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic [2:0]                 OP,
    input  logic [$clog2(NREGS)-1:0]   ADDR,
    input  logic [$clog2(NREGS)-1:0]   SRC,
    input  logic [WIDTH-1:0]           DATA,
    input  logic [$clog2(NREGS)-1:0]   RADDR,
    output logic [WIDTH-1:0]           RDATA,
    output logic [WIDTH-1:0]           RESULT,
    output logic [WIDTH-1:0]           RESULT_HI,
    output logic                       CARRY,
    output logic                       ZERO,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int ADDR_W  = $clog2(NREGS);
    localparam int c_CNT_W = $clog2(WIDTH);

    localparam logic [2:0] c_OP_NOP  = 3'b000;
    localparam logic [2:0] c_OP_LOAD = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_SUB  = 3'b011;
    localparam logic [2:0] c_OP_AND  = 3'b100;
    localparam logic [2:0] c_OP_OR   = 3'b101;
    localparam logic [2:0] c_OP_XOR  = 3'b110;
    localparam logic [2:0] c_OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_MUL_FIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_regs [NREGS];
    logic [ADDR_W-1:0]    r_mul_addr;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]     w_opa;
    logic [WIDTH-1:0]     w_opb;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_c;
    logic                 w_accept;
    logic                 w_wr_en;
    logic [ADDR_W-1:0]    w_wr_addr;
    logic [WIDTH-1:0]     w_wr_data;
    logic [WIDTH-1:0]     w_rd_next;

    // Operands are read from the current bank, so A==S sees pre-write values.
    assign w_opa    = r_regs[ADDR];
    assign w_opb    = r_regs[SRC];
    assign w_sum    = {1'b0, w_opa} + {1'b0, w_opb};
    assign w_diff   = {1'b0, w_opa} - {1'b0, w_opb};
    assign w_accept = (r_state == ST_IDLE) && START;

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (OP)
            c_OP_LOAD: w_alu_res = DATA;
            c_OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = w_diff[WIDTH];
            end
            c_OP_AND: w_alu_res = w_opa & w_opb;
            c_OP_OR:  w_alu_res = w_opa | w_opb;
            c_OP_XOR: w_alu_res = w_opa ^ w_opb;
            default: begin
                w_alu_res = '0;
                w_alu_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (w_accept && (OP != c_OP_NOP) && (OP != c_OP_MUL)) begin
            w_wr_en   = 1'b1;
            w_wr_addr = ADDR;
            w_wr_data = w_alu_res;
        end else if (r_state == ST_MUL_FIN) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_mul_addr;
            w_wr_data = r_acc[WIDTH-1:0];
        end
    end

    // Read port is write-first: it shows this edge's write to the same index.
    assign w_rd_next = (w_wr_en && (w_wr_addr == RADDR)) ? w_wr_data : r_regs[RADDR];

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_state    <= ST_IDLE;
            r_mul_addr <= '0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            RDATA      <= '0;
            RESULT     <= '0;
            RESULT_HI  <= '0;
            CARRY      <= 1'b0;
            ZERO       <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            DONE  <= 1'b0;
            RDATA <= w_rd_next;
            if (w_wr_en) begin
                r_regs[w_wr_addr] <= w_wr_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        if (OP == c_OP_MUL) begin
                            r_mul_addr <= ADDR;
                            r_mcand    <= {{WIDTH{1'b0}}, w_opa};
                            r_mplier   <= w_opb;
                            r_acc      <= '0;
                            r_cnt      <= '0;
                            BUSY       <= 1'b1;
                            r_state    <= ST_MUL_RUN;
                        end else begin
                            DONE <= 1'b1;
                            if (OP != c_OP_NOP) begin
                                RESULT    <= w_alu_res;
                                RESULT_HI <= '0;
                                CARRY     <= w_alu_c;
                                ZERO      <= (w_alu_res == '0);
                            end
                        end
                    end
                end
                ST_MUL_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_MUL_FIN;
                    end
                end
                ST_MUL_FIN: begin
                    RESULT    <= r_acc[WIDTH-1:0];
                    RESULT_HI <= r_acc[2*WIDTH-1:WIDTH];
                    CARRY     <= |r_acc[2*WIDTH-1:WIDTH];
                    ZERO      <= (r_acc == '0);
                    BUSY      <= 1'b0;
                    DONE      <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_alu_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_alu_array
//  Description : Directed, table-driven self-checking bench for reg_alu_array.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_alu_array;

    localparam int WIDTH = 8;
    localparam int NREGS = 4;
    localparam int AW    = 2;

    localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, ADD = 3'b010, SUB = 3'b011;
    localparam logic [2:0] AND = 3'b100, OR = 3'b101, XOR = 3'b110, MUL = 3'b111;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic [2:0]       OP;
    logic [AW-1:0]    ADDR;
    logic [AW-1:0]    SRC;
    logic [WIDTH-1:0] DATA;
    logic [AW-1:0]    RADDR;
    logic [WIDTH-1:0] RDATA;
    logic [WIDTH-1:0] RESULT;
    logic [WIDTH-1:0] RESULT_HI;
    logic             CARRY;
    logic             ZERO;
    logic             BUSY;
    logic             DONE;

    int checks   = 0;
    int failures = 0;

    reg_alu_array #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .ADDR(ADDR), .SRC(SRC),
        .DATA(DATA), .RADDR(RADDR), .RDATA(RDATA), .RESULT(RESULT),
        .RESULT_HI(RESULT_HI), .CARRY(CARRY), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]       op;
        logic [AW-1:0]    a;
        logic [AW-1:0]    s;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] hi;
        logic             c;
        logic             z;
        logic [WIDTH-1:0] rd;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Launch one op on a rising edge (DUT samples on the falling edge) and wait for DONE.
    task automatic run_op(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] s,
                          input logic [WIDTH-1:0] d, output bit got_done);
        @(posedge CLK);
        START = 1'b1; OP = op; ADDR = a; SRC = s; DATA = d; RADDR = a;
        @(posedge CLK);
        START = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (DONE) begin
                got_done = 1'b1;
                break;
            end
            @(posedge CLK);
        end
    endtask

    task automatic sweep_zero(input string tag);
        for (int r = 0; r < NREGS; r++) begin
            @(posedge CLK);
            RADDR = AW'(r);
            @(posedge CLK);
            chk($sformatf("%s_R%0d", tag, r), 32'(RDATA), 32'h0);
        end
    endtask

    initial begin
        bit got;
        int busy_cnt;
        int done_at;
        bit seen;

        vecs[0]  = '{LOAD, 2'd0, 2'd0, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 8'h05};
        vecs[1]  = '{LOAD, 2'd1, 2'd0, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 8'h03};
        vecs[2]  = '{ADD,  2'd0, 2'd1, 8'h00, 8'h08, 8'h00, 1'b0, 1'b0, 8'h08};
        vecs[3]  = '{LOAD, 2'd0, 2'd0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF};
        vecs[4]  = '{LOAD, 2'd1, 2'd0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01};
        vecs[5]  = '{ADD,  2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[6]  = '{LOAD, 2'd0, 2'd0, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 8'h03};
        vecs[7]  = '{LOAD, 2'd1, 2'd0, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 8'h05};
        vecs[8]  = '{SUB,  2'd0, 2'd1, 8'h00, 8'hFE, 8'h00, 1'b1, 1'b0, 8'hFE};
        vecs[9]  = '{SUB,  2'd1, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[10] = '{LOAD, 2'd2, 2'd0, 8'h0C, 8'h0C, 8'h00, 1'b0, 1'b0, 8'h0C};
        vecs[11] = '{LOAD, 2'd3, 2'd0, 8'h0B, 8'h0B, 8'h00, 1'b0, 1'b0, 8'h0B};
        vecs[12] = '{MUL,  2'd2, 2'd3, 8'h00, 8'h84, 8'h00, 1'b0, 1'b0, 8'h84};
        vecs[13] = '{LOAD, 2'd0, 2'd0, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 8'hA5};
        vecs[14] = '{LOAD, 2'd1, 2'd0, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C};
        vecs[15] = '{AND,  2'd0, 2'd1, 8'h00, 8'h24, 8'h00, 1'b0, 1'b0, 8'h24};
        vecs[16] = '{OR,   2'd0, 2'd1, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C};
        vecs[17] = '{XOR,  2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[18] = '{NOP,  2'd2, 2'd0, 8'h77, 8'h00, 8'h00, 1'b0, 1'b1, 8'h84};
        vecs[19] = '{ADD,  2'd2, 2'd2, 8'h00, 8'h08, 8'h00, 1'b1, 1'b0, 8'h08};
        vecs[20] = '{LOAD, 2'd3, 2'd0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF};
        vecs[21] = '{LOAD, 2'd2, 2'd0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF};
        vecs[22] = '{MUL,  2'd2, 2'd3, 8'h00, 8'h01, 8'hFE, 1'b1, 1'b0, 8'h01};
        vecs[23] = '{LOAD, 2'd3, 2'd0, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0, 8'h7F};
        vecs[24] = '{MUL,  2'd2, 2'd1, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C};
        vecs[25] = '{MUL,  2'd1, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00};

        RST = 1'b1; START = 1'b0; OP = NOP; ADDR = '0; SRC = '0; DATA = '0; RADDR = '0;
        repeat (2) @(posedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        chk("rst_result", 32'(RESULT), 32'h0);
        chk("rst_hi", 32'(RESULT_HI), 32'h0);
        chk("rst_flags", {28'h0, CARRY, ZERO, BUSY, DONE}, 32'h0);
        chk("rst_rdata", 32'(RDATA), 32'h0);

        for (int i = 0; i < 26; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].s, vecs[i].data, got);
            chk($sformatf("v%0d_done", i), 32'(got), 32'h1);
            chk($sformatf("v%0d_result", i), 32'(RESULT), 32'(vecs[i].res));
            chk($sformatf("v%0d_hi", i), 32'(RESULT_HI), 32'(vecs[i].hi));
            chk($sformatf("v%0d_carry", i), 32'(CARRY), 32'(vecs[i].c));
            chk($sformatf("v%0d_zero", i), 32'(ZERO), 32'(vecs[i].z));
            chk($sformatf("v%0d_rdata", i), 32'(RDATA), 32'(vecs[i].rd));
            chk($sformatf("v%0d_busy", i), 32'(BUSY), 32'h0);
        end

        // MUL latency, BUSY length, START ignored while busy, single-cycle DONE.
        run_op(LOAD, 2'd2, 2'd0, 8'h0C, got);
        run_op(LOAD, 2'd3, 2'd0, 8'h0B, got);
        @(posedge CLK);
        START = 1'b1; OP = MUL; ADDR = 2'd2; SRC = 2'd3; RADDR = 2'd2;
        busy_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= WIDTH + 6; k++) begin
            @(posedge CLK);
            if (k == 1) START = 1'b0;
            if (k == 3) begin
                START = 1'b1; OP = LOAD; ADDR = 2'd3; DATA = 8'h00;
            end
            if (k == 4) begin
                START = 1'b0; ADDR = 2'd2;
            end
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_at = k;
                break;
            end
        end
        chk("mul_done_edge", 32'(done_at), 32'(WIDTH + 2));
        chk("mul_busy_cycles", 32'(busy_cnt), 32'(WIDTH + 1));
        chk("mul_result", 32'(RESULT), 32'h84);
        chk("mul_rdata", 32'(RDATA), 32'h84);
        @(posedge CLK);
        chk("mul_done_pulse", 32'(DONE), 32'h0);
        RADDR = 2'd3;
        @(posedge CLK);
        chk("busy_load_ignored", 32'(RDATA), 32'h0B);

        // START held through the DONE cycle is accepted as a new op.
        @(posedge CLK);
        START = 1'b1; OP = LOAD; ADDR = 2'd0; DATA = 8'h11; RADDR = 2'd0;
        @(posedge CLK);
        chk("b2b_first", {23'h0, DONE, RESULT}, {23'h0, 1'b1, 8'h11});
        ADDR = 2'd1; DATA = 8'h22; RADDR = 2'd1;
        @(posedge CLK);
        START = 1'b0;
        chk("b2b_second", {23'h0, DONE, RESULT}, {23'h0, 1'b1, 8'h22});
        chk("b2b_rdata", 32'(RDATA), 32'h22);

        // Asynchronous reset between edges in the middle of a MUL.
        run_op(LOAD, 2'd2, 2'd0, 8'h0C, got);
        run_op(LOAD, 2'd3, 2'd0, 8'h0B, got);
        @(posedge CLK);
        START = 1'b1; OP = MUL; ADDR = 2'd2; SRC = 2'd3; RADDR = 2'd2;
        @(posedge CLK);
        START = 1'b0;
        repeat (3) @(posedge CLK);
        chk("pre_rst_busy", 32'(BUSY), 32'h1);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_busy", 32'(BUSY), 32'h0);
        chk("async_rst_result", 32'(RESULT), 32'h0);
        chk("async_rst_rdata", 32'(RDATA), 32'h0);
        @(posedge CLK);
        RST = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(posedge CLK);
            if (DONE || BUSY) seen = 1'b1;
        end
        chk("aborted_mul_silent", 32'(seen), 32'h0);
        sweep_zero("rst_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
